// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-buffer state encoding and the common data width.
package uart_pkg;

  typedef enum logic {READY = 1'b0, BUSY = 1'b1} txbuf_state_type;

  localparam int UART_DBIT = 8;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-file storage for the UART byte FIFOs: synchronous write, asynchronous read.
module uart_fifo_mem #(
  parameter int DBIT   = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [DBIT-1:0]   w_data,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [DBIT-1:0]   r_data
);

  logic [DBIT-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[w_addr] <= w_data;
  end

  assign r_data = mem[r_addr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte FIFO feeding the UART transmitter; offers the head byte and waits for
// the end of each frame before offering the next one.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DBIT   = UART_DBIT,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DBIT-1:0]   w_data,
  input  logic              flush,
  input  logic              clr_ovf,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              tx_start,
  output logic [DBIT-1:0]   tx_din,
  input  logic              cts,
  input  logic              tx_done_tick,
  output txbuf_state_type   state
);

  localparam int              DEPTH_I = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH   = DEPTH_I[ADDR_W:0];
  localparam logic [ADDR_W:0] CNT_ONE = 1;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_nxt;
  logic              accept, wr_acc, pop, ovf_nxt;
  txbuf_state_type   state_nxt;

  uart_fifo_mem #(.DBIT(DBIT), .ADDR_W(ADDR_W)) u_mem (
    .clk    (clk),
    .we     (wr_acc),
    .w_addr (wr_ptr),
    .w_data (w_data),
    .r_addr (rd_ptr),
    .r_data (tx_din)
  );

  // Handshake: tx_start is valid (head byte on tx_din), ~cts is ready; a byte
  // transfers on every edge where both are high, and tx_start never drops
  // while waiting for ready.
  always_comb begin
    accept    = tx_start & ~cts;
    wr_acc    = wr & ~full & ~flush;
    pop       = accept & ~flush;
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else if (wr_acc && !pop) begin
      count_nxt = count + CNT_ONE;
    end else if (pop && !wr_acc) begin
      count_nxt = count - CNT_ONE;
    end
    ovf_nxt = ovf;
    if (wr && full && !flush) begin
      ovf_nxt = 1'b1;
    end else if (clr_ovf) begin
      ovf_nxt = 1'b0;
    end
    // State follows the transmitter even across flush: an accepted byte completes.
    state_nxt = state;
    case (state)
      READY:   if (accept) state_nxt = BUSY;
      BUSY:    if (tx_done_tick) state_nxt = READY;
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      ovf      <= 1'b0;
      state    <= READY;
      tx_start <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)    rd_ptr <= rd_ptr + PTR_ONE;
      end
      count    <= count_nxt;
      full     <= (count_nxt == DEPTH);
      empty    <= (count_nxt == '0);
      ovf      <= ovf_nxt;
      state    <= state_nxt;
      tx_start <= (state_nxt == READY) && (count_nxt != '0);
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed bench for uart_tx_buffer with a simple transmitter model that
// accepts bytes on tx_start && ~cts and answers with tx_done_tick 160 cycles later.
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DBIT   = 8;
  localparam int ADDR_W = 4;
  localparam int TX_CYC = 160;

  logic              clk = 1'b0;
  logic              reset;
  logic              wr;
  logic [DBIT-1:0]   w_data;
  logic              flush;
  logic              clr_ovf;
  logic              full, empty, ovf, tx_start;
  logic [ADDR_W:0]   count;
  logic [DBIT-1:0]   tx_din;
  logic              cts;
  logic              tx_done_tick;
  txbuf_state_type   state;

  logic              auto_tx;
  logic              man_tick;
  logic              m_tick;
  logic              m_busy;
  int                m_timer;
  logic [DBIT-1:0]   got_q[$];

  int total = 0;
  int bad   = 0;

  uart_tx_buffer #(.DBIT(DBIT), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr           (wr),
    .w_data       (w_data),
    .flush        (flush),
    .clr_ovf      (clr_ovf),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .ovf          (ovf),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .cts          (cts),
    .tx_done_tick (tx_done_tick),
    .state        (state)
  );

  // clock / reset
  always #5 clk = ~clk;

  assign tx_done_tick = auto_tx ? m_tick : man_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // transmitter model: records each accepted byte and ends its frame after TX_CYC cycles
  always @(posedge clk) begin
    m_tick <= 1'b0;
    if (reset || !auto_tx) begin
      m_busy  <= 1'b0;
      m_timer <= 0;
    end else if (tx_start && !cts) begin
      chk("one_accept_per_done", 32'(m_busy), 32'd0);
      got_q.push_back(tx_din);
      m_busy  <= 1'b1;
      m_timer <= TX_CYC;
    end else if (m_busy) begin
      if (m_timer == 1) begin
        m_tick <= 1'b1;
        m_busy <= 1'b0;
      end
      m_timer <= m_timer - 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && !(!m_busy && !m_tick && state == READY && empty); i++) tick();
  endtask

  initial begin
    int peak;
    reset = 1'b1; wr = 1'b0; w_data = '0; flush = 1'b0; clr_ovf = 1'b0;
    cts = 1'b0; auto_tx = 1'b0; man_tick = 1'b0;
    tick(); tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_state", 32'(state), 32'(READY));
    reset = 1'b0;
    tick();

    // single byte
    wr = 1'b1; w_data = 8'hA5;
    tick();
    wr = 1'b0;
    chk("single_tx_start", 32'(tx_start), 32'd1);
    chk("single_tx_din", 32'(tx_din), 32'hA5);
    chk("single_count", 32'(count), 32'd1);
    tick();
    chk("single_state_busy", 32'(state), 32'(BUSY));
    chk("single_popped", 32'(empty), 32'd1);
    chk("single_busy_no_start", 32'(tx_start), 32'd0);
    tick(); tick(); tick();
    chk("single_still_no_start", 32'(tx_start), 32'd0);
    man_tick = 1'b1;
    tick();
    man_tick = 1'b0;
    chk("single_done_ready", 32'(state), 32'(READY));
    chk("single_done_empty", 32'(empty), 32'd1);
    chk("single_done_no_start", 32'(tx_start), 32'd0);
    tick();
    chk("single_done_no_start2", 32'(tx_start), 32'd0);

    // burst back-to-back
    auto_tx = 1'b1;
    got_q.delete();
    peak = 0;
    for (int i = 1; i <= 5; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    wr = 1'b0;
    for (int i = 0; i < 2000 && got_q.size() < 5; i++) begin
      tick();
      if (int'(count) > peak) peak = int'(count);
    end
    chk("burst_n", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) chk("burst_byte", 32'(got_q[i]), 32'(i + 1));
    chk("burst_peak", 32'(peak), 32'd4);
    wait_idle(400);

    // flow control
    got_q.delete();
    cts = 1'b1;
    wr = 1'b1; w_data = 8'h3C;
    tick();
    wr = 1'b0;
    peak = 1;
    for (int i = 0; i < 50; i++) begin
      if (!(tx_start === 1'b1 && tx_din === 8'h3C && count === 5'd1 && state === READY)) peak = 0;
      tick();
    end
    chk("cts_hold", 32'(peak), 32'd1);
    cts = 1'b0;
    chk("cts_offer", 32'(tx_start), 32'd1);
    tick();
    chk("cts_busy", 32'(state), 32'(BUSY));
    chk("cts_popped", 32'(count), 32'd0);
    chk("cts_byte", 32'(got_q.size() == 1 ? got_q[0] : 8'h00), 32'h3C);
    wait_idle(400);

    // full and overflow
    got_q.delete();
    cts = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      wr = 1'b1; w_data = 8'(i);
      tick();
      if (i == 15) begin
        chk("full_flag", 32'(full), 32'd1);
        chk("full_count", 32'(count), 32'd16);
        chk("full_no_ovf_yet", 32'(ovf), 32'd0);
      end
    end
    wr = 1'b0;
    chk("ovf_set", 32'(ovf), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clr", 32'(ovf), 32'd0);
    cts = 1'b0;
    wait_idle(4000);
    tick(); tick();
    chk("full_drain_n", 32'(got_q.size()), 32'd16);
    for (int i = 0; i < 16 && i < got_q.size(); i++) chk("full_drain_byte", 32'(got_q[i]), 32'(i));
    chk("full_drain_empty", 32'(empty), 32'd1);

    // wrap-around with random write gaps
    got_q.delete();
    for (int i = 0; i < 40; i++) begin
      for (int w = 0; w < 1000 && full; w++) tick();
      wr = 1'b1; w_data = 8'(8'h80 + i);
      tick();
      wr = 1'b0;
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    for (int i = 0; i < 10000 && got_q.size() < 40; i++) tick();
    chk("wrap_n", 32'(got_q.size()), 32'd40);
    for (int i = 0; i < 40 && i < got_q.size(); i++) chk("wrap_byte", 32'(got_q[i]), 32'(8'h80 + i));
    wait_idle(400);

    // flush mid-transmission
    auto_tx = 1'b0;
    cts = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      wr = 1'b1; w_data = 8'(8'h11 * i);
      tick();
    end
    wr = 1'b0;
    chk("flush_queued", 32'(count), 32'd3);
    cts = 1'b0;
    chk("flush_head", 32'(tx_din), 32'h11);
    tick();
    cts = 1'b1;
    chk("flush_accepted", 32'(state), 32'(BUSY));
    chk("flush_count_pre", 32'(count), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_empty", 32'(empty), 32'd1);
    chk("flush_state", 32'(state), 32'(BUSY));
    man_tick = 1'b1;
    tick();
    man_tick = 1'b0;
    chk("flush_done_ready", 32'(state), 32'(READY));
    chk("flush_done_no_start", 32'(tx_start), 32'd0);
    tick();
    chk("flush_done_no_start2", 32'(tx_start), 32'd0);
    wr = 1'b1; w_data = 8'h44;
    tick();
    wr = 1'b0;
    chk("flush_next_start", 32'(tx_start), 32'd1);
    chk("flush_next_byte", 32'(tx_din), 32'h44);
    cts = 1'b0;
    tick();
    chk("flush_next_busy", 32'(state), 32'(BUSY));

    // asynchronous reset mid-transmission
    #2;
    reset = 1'b1;
    #1;
    chk("arst_state", 32'(state), 32'(READY));
    chk("arst_start", 32'(tx_start), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    tick();
    reset = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
